// File: rtl/ysyx_23060124_pkg.sv
// Shared definitions for the ysyx_23060124 core: IFU state encoding, boot PC, AXI response codes.
package ysyx_23060124_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        OUT  = 3'd3,
        WB   = 3'd4
    } ifu_state_e;

    // Instructions are word sized; any low address bit set is a misaligned PC.
    function automatic logic pc_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060124_ifu_if.sv
// AXI4-Lite read channel (AR + R) between the fetch unit and instruction memory.
interface ysyx_23060124_ifu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word over AXI-Lite, hands {pc, instr} to decode,
// then waits for write-back to supply the next PC before fetching again.
module ysyx_23060124_ifu
    import ysyx_23060124_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                  clock,
    input  logic                  i_rst_n,
    input  logic [ADDR_W-1:0]     i_pc_next,
    input  logic                  i_pc_update,
    ysyx_23060124_ifu_if.master   axi,
    output logic                  o_post_valid,
    input  logic                  i_post_ready,
    output logic [ADDR_W-1:0]     o_pc,
    output logic [DATA_W-1:0]     o_ins,
    output logic                  o_err
);

    ifu_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ins_q;
    logic              err_q;

    logic ar_hs, r_hs, post_hs;

    // Handshakes only qualify the state transitions; valids below come purely from state_q.
    assign ar_hs   = axi.arvalid & axi.arready;
    assign r_hs    = axi.rready  & axi.rvalid;
    assign post_hs = o_post_valid & i_post_ready;

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ins_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= AR;
                    if (i_pc_update) err_q <= 1'b1;
                end
                AR: begin
                    if (ar_hs) state_q <= R;
                    if (i_pc_update) err_q <= 1'b1;
                end
                R: begin
                    if (r_hs) begin
                        ins_q   <= axi.rdata;
                        state_q <= OUT;
                        // A failed read still delivers its data; only the sticky flag records it.
                        if (axi.rresp != RESP_OKAY) err_q <= 1'b1;
                    end
                    if (i_pc_update) err_q <= 1'b1;
                end
                OUT: begin
                    if (post_hs) begin
                        if (i_pc_update) begin
                            pc_q    <= i_pc_next;
                            state_q <= AR;
                            if (pc_misaligned(i_pc_next[1:0])) err_q <= 1'b1;
                        end else begin
                            state_q <= WB;
                        end
                    end else if (i_pc_update) begin
                        err_q <= 1'b1;
                    end
                end
                WB: begin
                    if (i_pc_update) begin
                        pc_q    <= i_pc_next;
                        state_q <= AR;
                        if (pc_misaligned(i_pc_next[1:0])) err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi.arvalid  = (state_q == AR);
    assign axi.araddr   = {pc_q[ADDR_W-1:2], 2'b00};
    assign axi.rready   = (state_q == R);
    assign o_post_valid = (state_q == OUT);
    assign o_pc         = pc_q;
    assign o_ins        = ins_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Directed bench for the fetch unit: a transaction-level model checked every cycle plus literal spot checks.
module tb_ysyx_23060124_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_next = '0;
    logic        pc_update = 1'b0;
    logic        post_valid, post_ready;
    logic [31:0] o_pc, o_ins;
    logic        o_err;

    ysyx_23060124_ifu_if axi();

    ysyx_23060124_ifu dut (
        .clock(clock), .i_rst_n(rst_n), .i_pc_next(pc_next), .i_pc_update(pc_update),
        .axi(axi), .o_post_valid(post_valid), .i_post_ready(post_ready),
        .o_pc(o_pc), .o_ins(o_ins), .o_err(o_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: what the fetch unit owes, not how it is sequenced.
    logic [31:0] m_pc = RST_PC, m_ins = '0;
    logic        m_err = 0, m_wait = 0, m_ar_out = 0, m_pend = 0;
    int          ar_cnt = 0, post_cnt = 0;
    logic        p_arv = 0, p_arr = 0, p_pv = 0, p_pr = 0;
    logic [31:0] p_addr = '0, p_pc = '0, p_ins = '0;

    always @(negedge clock) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_ins = '0; m_err = 0; m_wait = 0; m_ar_out = 0; m_pend = 0;
            p_arv = 0; p_pv = 0;
            chk("rst_arvalid", {31'b0, axi.arvalid}, 32'd0);
            chk("rst_rready", {31'b0, axi.rready}, 32'd0);
            chk("rst_post_valid", {31'b0, post_valid}, 32'd0);
            chk("rst_pc", o_pc, RST_PC);
            chk("rst_ins", o_ins, 32'd0);
            chk("rst_err", {31'b0, o_err}, 32'd0);
        end else begin
            logic ar_hs, r_hs, p_hs;
            chk("m_pc", o_pc, m_pc);
            chk("m_ins", o_ins, m_ins);
            chk("m_err", {31'b0, o_err}, {31'b0, m_err});
            chk("m_rready", {31'b0, axi.rready}, {31'b0, m_ar_out});
            chk("m_post_valid", {31'b0, post_valid}, {31'b0, m_pend});
            if (axi.arvalid) chk("m_araddr", axi.araddr, {m_pc[31:2], 2'b00});
            if (axi.arvalid) chk("m_ar_single", {31'b0, m_ar_out | m_pend}, 32'd0);
            if (m_wait) chk("m_wb_idle", {29'b0, axi.arvalid, axi.rready, post_valid}, 32'd0);
            if (p_arv && !p_arr) begin
                chk("ar_hold_valid", {31'b0, axi.arvalid}, 32'd1);
                chk("ar_hold_addr", axi.araddr, p_addr);
            end
            if (p_pv && !p_pr) begin
                chk("post_hold_valid", {31'b0, post_valid}, 32'd1);
                chk("post_hold_pc", o_pc, p_pc);
                chk("post_hold_ins", o_ins, p_ins);
            end
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rready && axi.rvalid;
            p_hs  = post_valid && post_ready;
            if (ar_hs) begin m_ar_out = 1; ar_cnt++; end
            if (r_hs) begin
                m_ar_out = 0; m_pend = 1; m_ins = axi.rdata;
                if (axi.rresp != 2'b00) m_err = 1;
            end
            if (p_hs) begin m_pend = 0; post_cnt++; end
            if (pc_update) begin
                if (p_hs || m_wait) begin
                    m_pc = pc_next; m_wait = 0;
                    if (pc_next[1:0] != 2'b00) m_err = 1;
                end else m_err = 1;
            end else if (p_hs) m_wait = 1;
            p_arv = axi.arvalid; p_arr = axi.arready; p_addr = axi.araddr;
            p_pv = post_valid; p_pr = post_ready; p_pc = o_pc; p_ins = o_ins;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int ar_base, post_base;

    initial begin
        axi.arready = 1; axi.rvalid = 1; axi.rdata = 32'h0000_0413; axi.rresp = 2'b00;
        post_ready = 1;
        repeat (2) tick();
        rst_n = 1;
        // Boot fetch
        tick(); chk("boot_arvalid", {31'b0, axi.arvalid}, 32'd1);
        chk("boot_araddr", axi.araddr, 32'h8000_0000);
        tick(); chk("boot_rready", {31'b0, axi.rready}, 32'd1);
        tick(); chk("boot_post_valid", {31'b0, post_valid}, 32'd1);
        chk("boot_pc", o_pc, 32'h8000_0000); chk("boot_ins", o_ins, 32'h0000_0413);
        tick(); chk("wb_no_fetch", {30'b0, axi.arvalid, post_valid}, 32'd0);
        // Loop via WB
        pc_update = 1; pc_next = 32'h8000_0004;
        tick(); pc_update = 0; axi.rdata = 32'h0010_0093;
        chk("loop_arvalid", {31'b0, axi.arvalid}, 32'd1);
        chk("loop_araddr", axi.araddr, 32'h8000_0004);
        tick(); tick();
        chk("loop_post_pc", o_pc, 32'h8000_0004); chk("loop_post_ins", o_ins, 32'h0010_0093);
        // pc_update with post handshake: straight to AR, and stall it
        pc_update = 1; pc_next = 32'h8000_0008; axi.arready = 0;
        tick(); pc_update = 0;
        chk("direct_arvalid", {31'b0, axi.arvalid}, 32'd1);
        chk("direct_no_post", {31'b0, post_valid}, 32'd0);
        chk("direct_araddr", axi.araddr, 32'h8000_0008);
        ar_base = ar_cnt; post_base = post_cnt;
        repeat (3) tick();
        chk("stall_araddr", axi.araddr, 32'h8000_0008);
        axi.arready = 1; post_ready = 0;
        tick(); axi.rdata = 32'h0020_8113;
        tick(); chk("bp_post_valid", {31'b0, post_valid}, 32'd1);
        repeat (2) tick();
        chk("bp_post_held", {31'b0, post_valid}, 32'd1);
        chk("bp_pc", o_pc, 32'h8000_0008); chk("bp_ins", o_ins, 32'h0020_8113);
        post_ready = 1;
        tick(); chk("bp_one_ar", ar_cnt - ar_base, 1); chk("bp_one_post", post_cnt - post_base, 1);
        // Bus error
        pc_update = 1; pc_next = 32'h8000_000C; axi.rresp = 2'b10; axi.rdata = 32'hDEAD_BEEF;
        tick(); pc_update = 0;
        tick(); tick();
        chk("buserr_ins", o_ins, 32'hDEAD_BEEF); chk("buserr_err", {31'b0, o_err}, 32'd1);
        chk("buserr_pc", o_pc, 32'h8000_000C);
        tick(); axi.rresp = 2'b00;
        chk("buserr_sticky", {31'b0, o_err}, 32'd1);
        // Fresh boot, then pc_update while in R
        rst_n = 0; axi.rvalid = 0;
        tick(); chk("rst2_err", {31'b0, o_err}, 32'd0);
        tick(); rst_n = 1;
        tick(); tick();
        chk("perr_in_r", {31'b0, axi.rready}, 32'd1);
        pc_update = 1; pc_next = 32'h9000_0000;
        tick(); pc_update = 0;
        chk("perr_pc", o_pc, 32'h8000_0000); chk("perr_err", {31'b0, o_err}, 32'd1);
        axi.rvalid = 1; axi.rdata = 32'h0000_0013;
        tick(); tick();
        // Misaligned next PC
        pc_update = 1; pc_next = 32'h8000_0006;
        tick(); pc_update = 0;
        chk("mis_araddr", axi.araddr, 32'h8000_0004); chk("mis_pc", o_pc, 32'h8000_0006);
        chk("mis_err", {31'b0, o_err}, 32'd1);
        tick(); tick(); tick();
        // Reset in the middle of R
        pc_update = 1; pc_next = 32'h8000_0010;
        tick(); pc_update = 0; axi.rvalid = 0;
        tick(); chk("midr_rready", {31'b0, axi.rready}, 32'd1);
        rst_n = 0; #1;
        chk("midr_rst_rready", {31'b0, axi.rready}, 32'd0);
        chk("midr_rst_pc", o_pc, RST_PC); chk("midr_rst_err", {31'b0, o_err}, 32'd0);
        tick(); rst_n = 1; axi.rvalid = 1; axi.rdata = 32'h0000_0513;
        tick(); chk("late_r_ignored", {31'b0, axi.rready}, 32'd0);
        chk("reboot_araddr", axi.araddr, RST_PC);
        chk("reboot_arvalid", {31'b0, axi.arvalid}, 32'd1);
        tick(); tick();
        chk("reboot_pc", o_pc, RST_PC); chk("reboot_ins", o_ins, 32'h0000_0513);
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
